syn_pulse_counter: RTL

Event counter stage directly downstream of the three-flop input synchronizer. Consumes its single-cycle `sig_syn` pulse, applies a programmable re-trigger lockout, and accumulates accepted events in a two-digit BCD count (00–99) for the seven-segment display driver. A small run/stop/clear control FSM gates counting.

---
 rtl/syn_pulse_counter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/syn_pulse_counter.sv
// syn_pulse_counter
//   Counts single-cycle synchronized event pulses into a two-digit BCD value
//   (00-99) for the seven-segment driver. A run/stop control FSM gates
//   counting. After each accepted pulse, a programmable lockout ignores
//   re-triggers for LOCKOUT cycles.
//
// Parameters
//   LOCKOUT : cycles spent ignoring pulses after an accepted one (0 = none)
//   LW      : width of the lockout down-counter, LOCKOUT < 2**LW
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   sig_syn in   synchronized event pulse, one cycle per event
//   start   in   level, enables counting (IDLE -> RUN)
//   stop    in   level, disables counting and holds the count
//   clr     in   level, zeroes count and overflow flag
//   ones    out  BCD units digit (registered)
//   tens    out  BCD tens digit (registered)
//   ovf     out  sticky wrap flag 99 -> 00 (registered)
//   running out  high in RUN or LOCK (registered)
module syn_pulse_counter #(
  parameter int unsigned LOCKOUT = 4,
  parameter int unsigned LW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_syn,
  input  logic       start,
  input  logic       stop,
  input  logic       clr,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       ovf,
  output logic       running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t          state;
  logic [LW-1:0]   lock_cnt;
  logic            accept;
  logic [3:0]      ones_nx;
  logic [3:0]      tens_nx;
  logic            wrap;

  // BCD increment of the current count; wrap flags the 99 -> 00 rollover.
  always_comb begin
    accept  = (state == RUN) && sig_syn;
    ones_nx = ones + 4'd1;
    tens_nx = tens;
    wrap    = 1'b0;
    if (ones == 4'd9) begin
      ones_nx = '0;
      if (tens == 4'd9) begin
        tens_nx = '0;
        wrap    = 1'b1;
      end else begin
        tens_nx = tens + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lock_cnt <= '0;
      ones     <= '0;
      tens     <= '0;
      ovf      <= 1'b0;
      running  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state   <= IDLE;
            running <= 1'b0;
          end else if (sig_syn && (LOCKOUT != 0)) begin
            state    <= LOCK;
            lock_cnt <= LW'(LOCKOUT);
          end
        end
        LOCK: begin
          // Leaving when the counter steps from 1 to 0 keeps the FSM in
          // LOCK for exactly LOCKOUT cycles.
          if (stop) begin
            state    <= IDLE;
            running  <= 1'b0;
            lock_cnt <= '0;
          end else if (lock_cnt <= LW'(1)) begin
            state    <= RUN;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt - LW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          running  <= 1'b0;
          lock_cnt <= '0;
        end
      endcase

      // Clear wins over a same-cycle increment; the pulse is dropped.
      if (clr) begin
        ones <= '0;
        tens <= '0;
        ovf  <= 1'b0;
      end else if (accept) begin
        ones <= ones_nx;
        tens <= tens_nx;
        if (wrap) ovf <= 1'b1;
      end
    end
  end

endmodule
